reg_read_stage: RTL and testbench

REG_READ_STAGE -- requirements
Module: reg_read_stage

---
 rtl/reg_read_stage.sv | 167 ++++++++++++++++
 tb/tb_reg_read_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_stage.sv
// Operand-read stage: register file, write-pending scoreboard and a small
// IDLE/WAIT/OUT handshake FSM that stalls on RAW hazards and forwards the
// same-cycle write-back value into the operands it latches.
module reg_read_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        rs1_en_i,
  input  logic        rs2_en_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rd_en_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        wb_wen_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [63:0] wb_wdata_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [63:0] rs1_data_o,
  output logic [63:0] rs2_data_o,
  output logic [31:0] busy_o
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy, busy_n;
  logic              cap_rs1_en, cap_rs2_en;
  logic [AW-1:0]     cap_rs1_addr, cap_rs2_addr;
  logic              src1_en, src2_en;
  logic [AW-1:0]     src1_addr, src2_addr;
  logic              hazard, accept, latch, wb_write;
  logic [XLEN-1:0]   fwd1, fwd2;

  // A source stalls only on a pending write not satisfied by this cycle's write-back
  function automatic logic src_hazard(input logic en, input logic [AW-1:0] addr,
                                      input logic [NREG-1:0] bsy, input logic wen,
                                      input logic [AW-1:0] waddr);
    return en && (addr != '0) && bsy[addr] && !(wen && (waddr == addr));
  endfunction

  assign req_ready_o = (state == IDLE);
  assign op_valid_o  = (state == OUT);
  assign busy_o      = busy;
  assign accept      = req_valid_i & req_ready_o;
  assign wb_write    = wb_wen_i && (wb_addr_i != '0);

  // Live inputs are examined in IDLE; the captured request is re-examined in WAIT
  always_comb begin
    src1_en   = cap_rs1_en;
    src2_en   = cap_rs2_en;
    src1_addr = cap_rs1_addr;
    src2_addr = cap_rs2_addr;
    if (state == IDLE) begin
      src1_en   = rs1_en_i;
      src2_en   = rs2_en_i;
      src1_addr = rs1_addr_i;
      src2_addr = rs2_addr_i;
    end
  end

  // Hazard detection against the busy vector as it stood before this edge
  always_comb begin
    hazard = src_hazard(src1_en, src1_addr, busy, wb_wen_i, wb_addr_i) ||
             src_hazard(src2_en, src2_addr, busy, wb_wen_i, wb_addr_i);
  end

  // Operand values with same-cycle write-back forwarding; x0 and disabled read 0
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    if (src1_en && (src1_addr != '0))
      fwd1 = (wb_wen_i && (wb_addr_i == src1_addr)) ? wb_wdata_i : regs[src1_addr];
    if (src2_en && (src2_addr != '0))
      fwd2 = (wb_wen_i && (wb_addr_i == src2_addr)) ? wb_wdata_i : regs[src2_addr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; latch marks the edge on which operands are captured
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hazard) begin
            state_n = WAIT;
          end else begin
            state_n = OUT;
            latch   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!hazard) begin
          state_n = OUT;
          latch   = 1'b1;
        end
      end
      OUT: begin
        if (op_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Scoreboard update: write-back clears, reservation sets and wins on a tie
  always_comb begin
    busy_n = busy;
    if (wb_write) busy_n[wb_addr_i] = 1'b0;
    if (accept && rd_en_i && (rd_addr_i != '0)) busy_n[rd_addr_i] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Busy register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[wb_addr_i] <= wb_wdata_i;
    end
  end

  // Capture source selection on accept, held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_rs1_en   <= 1'b0;
      cap_rs2_en   <= 1'b0;
      cap_rs1_addr <= '0;
      cap_rs2_addr <= '0;
    end else if (accept) begin
      cap_rs1_en   <= rs1_en_i;
      cap_rs2_en   <= rs2_en_i;
      cap_rs1_addr <= rs1_addr_i;
      cap_rs2_addr <= rs2_addr_i;
    end
  end

  // Operand output registers, loaded only when entering OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_data_o <= '0;
      rs2_data_o <= '0;
    end else if (latch) begin
      rs1_data_o <= fwd1;
      rs2_data_o <= fwd2;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed hazard/forwarding/reset scenarios plus a
// random no-hazard phase, with expected operand pairs queued at request time.
module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic        rs1_en_i, rs2_en_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        rd_en_i;
  logic [4:0]  rd_addr_i;
  logic        wb_wen_i;
  logic [4:0]  wb_addr_i;
  logic [63:0] wb_wdata_i;
  logic        op_valid_o, op_ready_i;
  logic [63:0] rs1_data_o, rs2_data_o;
  logic [31:0] busy_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  logic [63:0]  mregs [32];

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rs1_en_i(rs1_en_i), .rs2_en_i(rs2_en_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .wb_wen_i(wb_wen_i), .wb_addr_i(wb_addr_i), .wb_wdata_i(wb_wdata_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive write-back for the next edge and track it in the model
  task automatic wb_set(input logic [4:0] a, input logic [63:0] d);
    wb_wen_i = 1'b1; wb_addr_i = a; wb_wdata_i = d;
  endtask

  task automatic wb_clr();
    if (wb_wen_i && wb_addr_i != 5'd0) mregs[wb_addr_i] = wb_wdata_i;
    wb_wen_i = 1'b0; wb_addr_i = '0; wb_wdata_i = '0;
  endtask

  task automatic wb_once(input logic [4:0] a, input logic [63:0] d);
    wb_set(a, d);
    tick();
    wb_clr();
  endtask

  function automatic logic [63:0] model_rd(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 64'd0;
    if (wb_wen_i && wb_addr_i == a) return wb_wdata_i;
    return mregs[a];
  endfunction

  // Present one request for exactly one edge; caller has any wb already driven
  task automatic issue(input logic e1, input logic [4:0] a1, input logic e2,
                       input logic [4:0] a2, input logic rde, input logic [4:0] rda);
    check("ready_before_issue", 64'(req_ready_o), 64'd1);
    rs1_en_i = e1; rs1_addr_i = a1; rs2_en_i = e2; rs2_addr_i = a2;
    rd_en_i = rde; rd_addr_i = rda; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0; rd_en_i = 1'b0;
  endtask

  // Scoreboard: each completed handshake pops and compares one operand pair
  always @(negedge clk) begin
    if (!rst && op_valid_o && op_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        check("sb_rs1", rs1_data_o, e[127:64]);
        check("sb_rs2", rs2_data_o, e[63:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid_i = 0; rs1_en_i = 0; rs2_en_i = 0; rs1_addr_i = 0;
    rs2_addr_i = 0; rd_en_i = 0; rd_addr_i = 0; wb_wen_i = 0; wb_addr_i = 0;
    wb_wdata_i = 0; op_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_valid", 64'(op_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_rs1", rs1_data_o, 64'd0);
    check("rst_rs2", rs2_data_o, 64'd0);

    // Basic read, one-cycle latency
    wb_once(5'd5, 64'h1234);
    exp_q.push_back({64'h1234, 64'd0});
    issue(1, 5'd5, 1, 5'd0, 0, 5'd0);
    check("basic_valid_lat1", 64'(op_valid_o), 64'd1);
    tick();

    // Stall on pending rd, released by write-back with forwarding
    exp_q.push_back({64'd0, 64'd0});
    issue(0, 5'd0, 0, 5'd0, 1, 5'd7);
    check("rd7_reserved", 64'(busy_o[7]), 64'd1);
    tick();
    exp_q.push_back({64'hAA, 64'd0});
    issue(1, 5'd7, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("wait_ready", 64'(req_ready_o), 64'd0);
      check("wait_valid", 64'(op_valid_o), 64'd0);
      tick();
    end
    wb_set(5'd7, 64'hAA);
    tick();
    wb_clr();
    check("wait_release_valid", 64'(op_valid_o), 64'd1);
    check("wait_release_busy7", 64'(busy_o[7]), 64'd0);
    tick();

    // Busy source satisfied by same-cycle write-back: no stall
    exp_q.push_back({64'd0, 64'd0});
    issue(0, 5'd0, 0, 5'd0, 1, 5'd3);
    tick();
    check("busy3_set", 64'(busy_o[3]), 64'd1);
    wb_set(5'd3, 64'h55);
    exp_q.push_back({model_rd(1, 5'd3), 64'd0});
    issue(1, 5'd3, 0, 5'd0, 0, 5'd0);
    wb_clr();
    check("fwd_no_wait_valid", 64'(op_valid_o), 64'd1);
    check("fwd_busy3_clear", 64'(busy_o[3]), 64'd0);
    tick();

    // Source equal to own rd does not self-stall; reservation beats clear
    wb_once(5'd9, 64'h10);
    exp_q.push_back({64'h10, 64'd0});
    issue(1, 5'd9, 0, 5'd0, 1, 5'd9);
    check("self_rd_valid", 64'(op_valid_o), 64'd1);
    check("self_rd_busy9", 64'(busy_o[9]), 64'd1);
    tick();
    wb_set(5'd9, 64'h20);
    exp_q.push_back({64'd0, 64'd0});
    issue(0, 5'd0, 0, 5'd0, 1, 5'd9);
    wb_clr();
    check("set_wins_busy9", 64'(busy_o[9]), 64'd1);
    tick();
    wb_once(5'd9, 64'h20);
    check("busy9_cleared", 64'(busy_o[9]), 64'd0);

    // Held outputs under back-pressure ignore later writes
    wb_once(5'd12, 64'h777);
    op_ready_i = 1'b0;
    exp_q.push_back({64'h777, 64'h1234});
    issue(1, 5'd12, 1, 5'd5, 0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 64'(op_valid_o), 64'd1);
      check("hold_ready", 64'(req_ready_o), 64'd0);
      check("hold_rs1", rs1_data_o, 64'h777);
      check("hold_rs2", rs2_data_o, 64'h1234);
      wb_set(5'd12, 64'hDEAD + 64'(i));
      tick();
      wb_clr();
    end
    op_ready_i = 1'b1;
    tick();
    check("post_hold_valid", 64'(op_valid_o), 64'd0);
    check("post_hold_ready", 64'(req_ready_o), 64'd1);
    check("idle_keeps_rs1", rs1_data_o, 64'h777);

    // Reset while waiting abandons the request and blocks the same-edge write
    exp_q.push_back({64'd0, 64'd0});
    issue(0, 5'd0, 0, 5'd0, 1, 5'd20);
    tick();
    issue(1, 5'd20, 0, 5'd0, 0, 5'd0);
    check("pre_rst_wait_ready", 64'(req_ready_o), 64'd0);
    rst = 1'b1;
    wb_set(5'd21, 64'h99);
    tick();
    wb_wen_i = 1'b0; wb_addr_i = '0; wb_wdata_i = '0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    check("mid_rst_ready", 64'(req_ready_o), 64'd1);
    check("mid_rst_valid", 64'(op_valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_rs1", rs1_data_o, 64'd0);
    exp_q.push_back({64'd0, 64'd0});
    issue(1, 5'd5, 1, 5'd21, 0, 5'd0);
    tick();
    exp_q.push_back({64'd0, 64'd0});
    issue(1, 5'd12, 1, 5'd9, 0, 5'd0);
    tick();

    // Random writes and reads without reservations, with occasional forwarding
    for (int n = 0; n < 40; n++) begin
      logic [4:0] a1, a2;
      logic e1, e2;
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      e1 = 1'($urandom_range(0, 1));
      e2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0)
        wb_set(($urandom_range(0, 1) != 0) ? a1 : 5'($urandom_range(0, 31)),
               {$urandom, $urandom});
      exp_q.push_back({model_rd(e1, a1), model_rd(e2, a2)});
      issue(e1, a1, e2, a2, 0, 5'd0);
      wb_clr();
      if ($urandom_range(0, 1) != 0) wb_set(5'($urandom_range(0, 31)), {$urandom, $urandom});
      tick();
      wb_clr();
    end

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
